// File: rtl/fxyz_pkg.sv
// rtl/fxyz_pkg.sv - shared types and constants for the fxyz truth-table sweeper
package fxyz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } fxyz_state_t;

    localparam int FXYZ_NCOMB = 8;
    localparam int FXYZ_IDX_W = 3;

endpackage

// File: rtl/fxyz_tbl_cmp.sv
// rtl/fxyz_tbl_cmp.sv - compares a captured truth table against a reference and counts differing bits
module fxyz_tbl_cmp
    import fxyz_pkg::*;
#(
    parameter logic [7:0] EXPECTED = 8'h00
) (
    input  logic [FXYZ_NCOMB-1:0] i_tbl,
    output logic                  o_pass,
    output logic [3:0]            o_err_cnt
);

    logic [FXYZ_NCOMB-1:0] w_diff;

    assign w_diff = i_tbl ^ EXPECTED;
    assign o_pass = (w_diff == '0);

    // popcount of the mismatching rows
    always_comb begin
        o_err_cnt = 4'd0;
        for (int i = 0; i < FXYZ_NCOMB; i++) begin
            o_err_cnt = o_err_cnt + 4'(w_diff[i]);
        end
    end

endmodule

// File: rtl/fxyz_sweeper.sv
// rtl/fxyz_sweeper.sv - walks X/Y/Z through all eight rows and captures F; optional compare under FXYZ_SWEEP_CHECK_EN
module fxyz_sweeper
    import fxyz_pkg::*;
#(
    parameter int         SETTLE   = 2,
    parameter logic [7:0] EXPECTED = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    output logic       x_out,
    output logic       y_out,
    output logic       z_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tbl,
    output logic       tbl_valid,
    output logic       pass,
    output logic [3:0] err_cnt
);

    localparam logic [3:0]            CNT_LAST = 4'(SETTLE - 1);
    localparam logic [FXYZ_IDX_W-1:0] IDX_LAST = FXYZ_IDX_W'(FXYZ_NCOMB - 1);

    fxyz_state_t           r_state;
    fxyz_state_t           w_state_next;
    logic [FXYZ_IDX_W-1:0] r_idx;
    logic [3:0]            r_cnt;
    logic [7:0]            r_tbl;
    logic                  r_tbl_valid;
    logic [7:0]            w_tbl_next;
    logic                  w_begin;
    logic                  w_abort;
    logic                  w_sample;
    logic                  w_last;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next state and per-cycle control strobes; abort wins over a sample in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_begin      = 1'b0;
        w_abort      = 1'b0;
        w_sample     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_begin      = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_sample = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_last       = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // table with the current row's F merged in; also feeds the compare so pass/err_cnt see the final bit
    always_comb begin
        w_tbl_next        = r_tbl;
        w_tbl_next[r_idx] = f_in;
    end

    // row index, settle counter and captured table
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_cnt       <= 4'd0;
            r_tbl       <= 8'h00;
            r_tbl_valid <= 1'b0;
        end else begin
            if (w_begin) begin
                r_idx       <= '0;
                r_cnt       <= 4'd0;
                r_tbl       <= 8'h00;
                r_tbl_valid <= 1'b0;
            end else if (w_abort) begin
                r_idx <= '0;
                r_cnt <= 4'd0;
            end else if (w_sample) begin
                r_tbl <= w_tbl_next;
                r_cnt <= 4'd0;
                if (w_last) begin
                    r_tbl_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if (r_state == ST_SETTLE) begin
                r_cnt <= r_cnt + 4'd1;
            end else if (r_state == ST_DONE) begin
                r_idx <= '0;
            end
        end
    end

`ifdef FXYZ_SWEEP_CHECK_EN
    logic       w_pass;
    logic [3:0] w_err_cnt;
    logic       r_pass;
    logic [3:0] r_err_cnt;

    fxyz_tbl_cmp #(
        .EXPECTED (EXPECTED)
    ) u_cmp (
        .i_tbl     (w_tbl_next),
        .o_pass    (w_pass),
        .o_err_cnt (w_err_cnt)
    );

    // compare result captured alongside tbl_valid, cleared when a new sweep begins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass    <= 1'b0;
            r_err_cnt <= 4'd0;
        end else if (w_begin) begin
            r_pass    <= 1'b0;
            r_err_cnt <= 4'd0;
        end else if (w_last) begin
            r_pass    <= w_pass;
            r_err_cnt <= w_err_cnt;
        end
    end

    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_expected;
    assign w_unused_expected = ^EXPECTED;
    assign pass              = 1'b0;
    assign err_cnt           = 4'd0;
`endif

    assign {x_out, y_out, z_out} = r_idx;
    assign busy                  = (r_state == ST_SETTLE);
    assign done                  = (r_state == ST_DONE);
    assign tbl                   = r_tbl;
    assign tbl_valid             = r_tbl_valid;

endmodule

// File: tb/tb_fxyz_sweeper.sv
// tb/tb_fxyz_sweeper.sv - self-checking bench for fxyz_sweeper against a row-level reference model
module tb_fxyz_sweeper;

    localparam int         S0   = 2;
    localparam int         S1   = 1;
    localparam logic [7:0] EXP0 = 8'hEA;
    localparam logic [7:0] EXP1 = 8'hE8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, abort0, f0, x0, y0, z0, busy0, done0, tv0, pass0;
    logic [7:0] tbl0;
    logic [3:0] err0;
    logic       start1, abort1, f1, x1, y1, z1, busy1, done1, tv1, pass1;
    logic [7:0] tbl1;
    logic [3:0] err1;

    logic [7:0] func0, func1;
    logic       use_drv0, f_drv0;

    int n_checks = 0;
    int n_pass   = 0;

    assign f0 = use_drv0 ? f_drv0 : func0[{x0, y0, z0}];
    assign f1 = func1[{x1, y1, z1}];

    fxyz_sweeper #(.SETTLE(S0), .EXPECTED(EXP0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .f_in(f0),
        .x_out(x0), .y_out(y0), .z_out(z0), .busy(busy0), .done(done0),
        .tbl(tbl0), .tbl_valid(tv0), .pass(pass0), .err_cnt(err0)
    );

    fxyz_sweeper #(.SETTLE(S1), .EXPECTED(EXP1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .f_in(f1),
        .x_out(x1), .y_out(y1), .z_out(z1), .busy(busy1), .done(done1),
        .tbl(tbl1), .tbl_valid(tv1), .pass(pass1), .err_cnt(err1)
    );

    // reference: compare outputs exist only in the checking build
    function automatic logic model_pass(input logic [7:0] t, input logic [7:0] e);
`ifdef FXYZ_SWEEP_CHECK_EN
        return (t == e);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] model_err(input logic [7:0] t, input logic [7:0] e);
`ifdef FXYZ_SWEEP_CHECK_EN
        return 4'($countones(t ^ e));
`else
        return 4'd0;
`endif
    endfunction

    function automatic logic [7:0] stub_table();
        logic [7:0] t;
        for (int n = 0; n < 8; n++) begin
            logic [2:0] v;
            v    = 3'(n);
            t[n] = (v[2] & v[1]) | v[0];
        end
        return t;
    endfunction

    // one sweep on dut0; entered and left just after a falling edge with dut0 idle
    task automatic sweep0(input logic [7:0] f, input bit noise, input bit mid_start, output int lat);
        int e;
        bit seen;
        func0    = f;
        use_drv0 = noise;
        f_drv0   = 1'b0;
        start0   = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        e      = 0;
        seen   = 1'b0;
        lat    = -1;
        while (e <= 8*S0 + 2 && !seen) begin
            if (e < 8*S0) begin
                n_checks++;
                if ({busy0, x0, y0, z0, done0, tv0} !== {1'b1, 3'(e/S0), 1'b0, 1'b0})
                    $display("FAIL sweep_step e=%0d got busy,xyz,done,tv=%b want %b", e,
                             {busy0, x0, y0, z0, done0, tv0}, {1'b1, 3'(e/S0), 1'b0, 1'b0});
                else n_pass++;
            end
            if (e == 0) begin
                n_checks++;
                if ({pass0, err0} !== 5'd0)
                    $display("FAIL cleared_on_start got pass,err=%b want 0", {pass0, err0});
                else n_pass++;
            end
            if (done0) begin
                seen = 1'b1;
                lat  = e + 1;
                n_checks++;
                if ({tbl0, tv0, pass0, err0} !== {f, 1'b1, model_pass(f, EXP0), model_err(f, EXP0)})
                    $display("FAIL sweep_result got tbl=%h tv=%b pass=%b err=%0d want tbl=%h tv=1 pass=%b err=%0d",
                             tbl0, tv0, pass0, err0, f, model_pass(f, EXP0), model_err(f, EXP0));
                else n_pass++;
            end
            start0 = (mid_start && e == 5) ? 1'b1 : 1'b0;
            if (noise) f_drv0 = (((e + 1) % S0) == 0) ? f[e/S0] : 1'($urandom);
            @(negedge clk);
            e++;
        end
        start0   = 1'b0;
        use_drv0 = 1'b0;
        n_checks++;
        if (!seen) $display("FAIL done_timeout got no done within %0d cycles", 8*S0 + 3);
        else if (done0 !== 1'b0) $display("FAIL done_pulse_width got done=%b want 0", done0);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({x0, y0, z0, busy0, done0, tv0, pass0, tbl0, err0} !== 19'd0)
            $display("FAIL reset_dut0 got %h want 0", {x0, y0, z0, busy0, done0, tv0, pass0, tbl0, err0});
        else n_pass++;
        n_checks++;
        if ({x1, y1, z1, busy1, done1, tv1, pass1, tbl1, err1} !== 19'd0)
            $display("FAIL reset_dut1 got %h want 0", {x1, y1, z1, busy1, done1, tv1, pass1, tbl1, err1});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy0, done0, busy1, done1} !== 4'd0)
            $display("FAIL idle_after_reset got busy/done=%b want 0", {busy0, done0, busy1, done1});
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        sweep0(stub_table(), 1'b0, 1'b0, lat);
        n_checks++;
        if (lat != 8*S0 + 1) $display("FAIL basic_latency got %0d want %0d", lat, 8*S0 + 1);
        else n_pass++;
        n_checks++;
        if (stub_table() !== tbl0) $display("FAIL basic_tbl got %h want EA", tbl0);
        else n_pass++;
    endtask

    task automatic test_abort();
        int  lat;
        bit  saw_done;
        func0  = 8'($urandom);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3*S0) @(negedge clk);
        n_checks++;
        if ({busy0, x0, y0, z0} !== 4'b1011) $display("FAIL abort_pre got busy,xyz=%b want 1011", {busy0, x0, y0, z0});
        else n_pass++;
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_checks++;
        if ({busy0, x0, y0, z0, done0, tv0} !== 6'd0)
            $display("FAIL abort_idle got busy,xyz,done,tv=%b want 0", {busy0, x0, y0, z0, done0, tv0});
        else n_pass++;
        saw_done = 1'b0;
        repeat (8*S0 + 4) begin
            @(negedge clk);
            if (done0 || busy0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) $display("FAIL abort_quiet got activity after abort want none");
        else n_pass++;
        sweep0(8'($urandom), 1'b0, 1'b0, lat);
        n_checks++;
        if (lat != 8*S0 + 1) $display("FAIL abort_restart_latency got %0d want %0d", lat, 8*S0 + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dq[$];
        int lat;
        func0  = 8'($urandom);
        start0 = 1'b1;
        @(negedge clk);
        for (int e = 0; e < 40; e++) begin
            if (done0) dq.push_back(e);
            @(negedge clk);
        end
        start0 = 1'b0;
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_checks++;
        if (dq.size() != 2) $display("FAIL b2b_count got %0d dones want 2", dq.size());
        else if (dq[0] != 8*S0 || dq[1] - dq[0] != 8*S0 + 2)
            $display("FAIL b2b_spacing got first=%0d gap=%0d want %0d and %0d", dq[0], dq[1] - dq[0], 8*S0, 8*S0 + 2);
        else n_pass++;
        n_checks++;
        if (busy0 !== 1'b0) $display("FAIL b2b_stop got busy=%b want 0", busy0);
        else n_pass++;
        sweep0(8'($urandom), 1'b0, 1'b1, lat);
        n_checks++;
        if (lat != 8*S0 + 1) $display("FAIL midstart_latency got %0d want %0d", lat, 8*S0 + 1);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0) $display("FAIL midstart_not_queued got busy=%b want 0", busy0);
        else n_pass++;
    endtask

    task automatic test_noise();
        int lat;
        for (int i = 0; i < 4; i++) begin
            sweep0(8'($urandom), 1'b1, 1'b0, lat);
        end
    endtask

    task automatic test_settle1();
        logic [7:0] f;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            f      = (i == 0) ? stub_table() : 8'($urandom);
            func1  = f;
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            lat    = -1;
            for (int e = 0; e < 20 && lat < 0; e++) begin
                if (e < 8) begin
                    n_checks++;
                    if ({busy1, x1, y1, z1} !== {1'b1, 3'(e)})
                        $display("FAIL s1_step e=%0d got busy,xyz=%b want %b", e, {busy1, x1, y1, z1}, {1'b1, 3'(e)});
                    else n_pass++;
                end
                if (done1) lat = e + 1;
                else @(negedge clk);
            end
            n_checks++;
            if (lat != 9) $display("FAIL s1_latency got %0d want 9", lat);
            else n_pass++;
            n_checks++;
            if ({tbl1, tv1, pass1, err1} !== {f, 1'b1, model_pass(f, EXP1), model_err(f, EXP1)})
                $display("FAIL s1_result got tbl=%h tv=%b pass=%b err=%0d want tbl=%h pass=%b err=%0d",
                         tbl1, tv1, pass1, err1, f, model_pass(f, EXP1), model_err(f, EXP1));
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        func0  = 8'hFF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5*S0) @(negedge clk);
        n_checks++;
        if ({busy0, x0, y0, z0} !== 4'b1101) $display("FAIL mid_reset_pre got busy,xyz=%b want 1101", {busy0, x0, y0, z0});
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({x0, y0, z0, busy0, done0, tv0, pass0, tbl0, err0} !== 19'd0)
            $display("FAIL mid_reset got %h want 0", {x0, y0, z0, busy0, done0, tv0, pass0, tbl0, err0});
        else n_pass++;
        sweep0(stub_table(), 1'b0, 1'b0, lat);
        n_checks++;
        if (lat != 8*S0 + 1) $display("FAIL post_reset_latency got %0d want %0d", lat, 8*S0 + 1);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        {start0, abort0, start1, abort1} = 4'd0;
        func0    = 8'h00;
        func1    = 8'h00;
        use_drv0 = 1'b0;
        f_drv0   = 1'b0;
        test_reset();
        test_basic();
        test_settle1();
        test_abort();
        test_back_to_back();
        test_noise();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fxyz_sweeper.md
# fxyz_sweeper

Sequencer that drives the `fxyz` combinational function through all eight X/Y/Z input combinations. After each combination has settled for a programmable number of cycles, it samples F and assembles an 8-bit truth table. It sits between a host/control port and an `fxyz` instance, turning bench-style exhaustive evaluation into a synthesizable start/done block.

## Interface
- `SETTLE`, 2: cycles each combination is held before F is sampled; legal range 1..15.
- `EXPECTED`, 8'h00: reference truth table, bit n = F for {X,Y,Z}=n. Used only with `FXYZ_SWEEP_CHECK_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `abort`  in  1  cancel sweep; sampled in SETTLE.
- `f_in`  in  1  F output of the driven `fxyz`.
- `x_out`, `y_out`, `z_out`  out  1 each  drive `fxyz` X, Y, Z.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `tbl`  out  8  captured truth table.
- `tbl_valid`  out  1  `tbl` holds a complete sweep.
- `pass`  out  1  `tbl == EXPECTED`; meaningful only when `tbl_valid`=1.
- `err_cnt`  out  4  popcount(`tbl ^ EXPECTED`), 0..8.

## Operation
- States: IDLE, SETTLE, DONE. Internal registers: `idx[2:0]` and `cnt[3:0]`. Outputs are driven as {`x_out`,`y_out`,`z_out`} = `idx`, so X is the MSB and Z the LSB (X outer loop, Z inner).
- IDLE, `start`=1:
  - idx←0, cnt←0, `tbl`←0, `tbl_valid`←0;
  - go to SETTLE.
- SETTLE, `abort`=1: go to IDLE, idx←0. `tbl_valid` stays 0 and no `done` pulse is issued. `abort` has priority over sampling.
- SETTLE, cnt≠SETTLE-1: cnt←cnt+1.
- SETTLE, cnt=SETTLE-1:
  - `tbl[idx]`←`f_in`, cnt←0;
  - if idx=7, go to DONE; otherwise idx←idx+1.
- DONE: `done`=1 and `tbl_valid`←1 for one cycle, idx←0, then go to IDLE. No wrap of idx to a second sweep.
- `start` in SETTLE or DONE is ignored and is not queued.
- `abort` in IDLE or DONE is ignored.
- `busy` = (state==SETTLE).
- Reset, including mid-sweep: on the next edge all outputs return to their reset values.
- Reset values:
  - state IDLE;
  - `x_out`/`y_out`/`z_out` 0;
  - `busy` 0, `done` 0;
  - `tbl` 8'h00, `tbl_valid` 0;
  - `pass` 0, `err_cnt` 0.

## Timing
- Start edge k: X/Y/Z=000 visible after edge k, `busy`=1.
- Combination n is held for exactly SETTLE cycles and sampled at edge k+(n+1)·SETTLE.
- `done` is high in the cycle after edge k+8·SETTLE. `tbl_valid` rises on the same edge.
- Total latency from `start` to `done` high is 8·SETTLE+1 cycles.
- The earliest accepted restart is the cycle after `done`.
- `pass`/`err_cnt` are registered and update on the same edge as `tbl_valid`.

## Configuration
- `FXYZ_SWEEP_CHECK_EN` defined:
  - a compare stage computes `pass` and `err_cnt` from the final `tbl` and `EXPECTED`;
  - both are cleared on `start`.
- `FXYZ_SWEEP_CHECK_EN` undefined: the compare logic is removed and `pass`/`err_cnt` are tied to 0. The port list is identical in both builds.

## Structure
- Shared package `fxyz_pkg`:
  - state encoding typedef (IDLE=2'd0, SETTLE=2'd1, DONE=2'd2);
  - `FXYZ_NCOMB`=8;
  - `FXYZ_IDX_W`=3.
- One natural sub-module: `fxyz_tbl_cmp` (popcount compare), instantiated only under `FXYZ_SWEEP_CHECK_EN`.
- `fxyz` itself is instantiated by the parent, not inside this block.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, release → all outputs 0, `busy`=0, no `done`.
- Basic sweep, SETTLE=2, `f_in` stub = X&Y|Z:
  - `done` pulses 17 cycles after `start`;
  - `tbl`=8'hEA, `tbl_valid`=1;
  - X/Y/Z step 000→111, each combination held 2 cycles.
- Check path, with macro, EXPECTED=8'hEA then 8'hE8:
  - `pass`=1, `err_cnt`=0;
  - then `pass`=0, `err_cnt`=1.
  - Without macro: both outputs stay 0.
- Abort at combination 3 (idx=3): back to IDLE next edge, no `done`, `tbl_valid`=0, X/Y/Z=000. A new `start` completes normally.
- Ignored start and back-to-back sweeps:
  - `start` held high throughout → exactly one sweep per IDLE entry, consecutive sweeps spaced 18 cycles;
  - a `start` pulse mid-sweep does not extend the sweep.
- Boundaries and mid-sweep reset:
  - SETTLE=1: `done` 9 cycles after `start`;
  - `rst` asserted at combination 5 → reset values next edge;
  - `f_in` toggled in non-sample cycles does not affect `tbl`.
